// File: rtl/zorro_master.sv
// ----------------------------------------------------------------------------
// zorro_master
// Bus master for a Zorro-style asynchronous bus.  A local request is latched in
// IDLE and then run as one bus cycle: the address phase (ADDR), the full cycle
// strobe (STROBE), the data strobes while waiting for the responder (WAIT) and
// the release of all strobes until the responder lets go of DTACK (RELEASE).
// The cycle ends with a single ack pulse (DONE).  err rides on that pulse when
// the responder signalled BERR or when no DTACK arrived within TIMEOUT cycles.
//
// Ports
//   CLK, RESET       clock, asynchronous active-high reset
//   req              local request, looked at only in IDLE
//   req_addr/read    target address and direction (1 = read)
//   req_wdata/be     write data and active-high byte enables (bit 3 = D[31:24])
//   busy             high whenever the master is not idle
//   ack, err         one-cycle completion pulse and its error qualifier
//   rdata            last successfully read word, held until the next read
//   ADDR, READ       bus address and direction
//   FCS_n, DS_n      full cycle strobe and data strobes, active-low
//   DOE, D_out       write data enable and write data towards the bus
//   D_in             read data from the bus
//   DTACK, BERR      asynchronous acknowledge and bus error from the responder
// ----------------------------------------------------------------------------
module zorro_master #(
    parameter int TIMEOUT = 64
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        req,
    input  logic [31:0] req_addr,
    input  logic        req_read,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        busy,
    output logic        ack,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] ADDR,
    output logic        READ,
    output logic        FCS_n,
    output logic [3:0]  DS_n,
    output logic        DOE,
    output logic [31:0] D_out,
    input  logic [31:0] D_in,
    input  logic        DTACK,
    input  logic        BERR
);

    // The counter only has to reach TIMEOUT-1, never beyond it.
    localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_STROBE,
        ST_WAIT,
        ST_RELEASE,
        ST_DONE
    } state_t;

    state_t           state;
    state_t           next_state;
    logic             dtack_meta;
    logic             dtack_sync;
    logic             berr_meta;
    logic             berr_sync;
    logic [31:0]      wdata_q;
    logic [3:0]       be_q;
    logic [CNT_W-1:0] cnt;
    logic             err_flag;
    logic             cnt_at_last;

    assign cnt_at_last = (cnt == CNT_LAST);
    assign D_out       = wdata_q;

    // DTACK and BERR come from another clock domain; only the second flop of
    // each pair is ever looked at by the control logic.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            dtack_meta <= 1'b0;
            dtack_sync <= 1'b0;
            berr_meta  <= 1'b0;
            berr_sync  <= 1'b0;
        end else begin
            dtack_meta <= DTACK;
            dtack_sync <= dtack_meta;
            berr_meta  <= BERR;
            berr_sync  <= berr_meta;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (req) next_state = ST_ADDR;
            ST_ADDR:    next_state = ST_STROBE;
            ST_STROBE:  next_state = ST_WAIT;
            ST_WAIT:    if (berr_sync || dtack_sync || cnt_at_last) next_state = ST_RELEASE;
            // Wait for the responder to drop DTACK, but never forever.
            ST_RELEASE: if (!dtack_sync || cnt_at_last) next_state = ST_DONE;
            ST_DONE:    next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    // Request latch, read data capture, error flag and the timeout counter.
    // BERR is tested before DTACK so a simultaneous error never updates rdata.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ADDR     <= 32'h0;
            READ     <= 1'b1;
            wdata_q  <= 32'h0;
            be_q     <= 4'h0;
            rdata    <= 32'h0;
            cnt      <= '0;
            err_flag <= 1'b0;
        end else begin
            if (state == ST_IDLE && req) begin
                ADDR    <= req_addr;
                READ    <= req_read;
                wdata_q <= req_wdata;
                be_q    <= req_be;
            end

            case (state)
                ST_WAIT: begin
                    if (berr_sync) begin
                        err_flag <= 1'b1;
                    end else if (dtack_sync) begin
                        if (READ) rdata <= D_in;
                    end else if (cnt_at_last) begin
                        err_flag <= 1'b1;
                    end
                    // Leaving WAIT clears the counter for the RELEASE bound.
                    if (next_state == ST_RELEASE) cnt <= '0;
                    else                          cnt <= cnt + CNT_W'(1);
                end
                ST_RELEASE: begin
                    if (!cnt_at_last) cnt <= cnt + CNT_W'(1);
                end
                ST_DONE: begin
                    cnt      <= '0;
                    err_flag <= 1'b0;
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        busy  = (state != ST_IDLE);
        ack   = 1'b0;
        err   = 1'b0;
        FCS_n = 1'b1;
        DS_n  = 4'hF;
        DOE   = 1'b0;
        case (state)
            ST_STROBE: begin
                FCS_n = 1'b0;
            end
            ST_WAIT: begin
                FCS_n = 1'b0;
                DS_n  = ~be_q;
                DOE   = ~READ;
            end
            ST_DONE: begin
                ack = 1'b1;
                err = err_flag;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_zorro_master.sv
// ----------------------------------------------------------------------------
// tb_zorro_master
// Directed bench for zorro_master with a simple bus responder that answers a
// fixed number of cycles after FCS_n falls.  Expected ack/err/rdata for every
// bus cycle are queued when the request is issued and popped when ack shows.
// ----------------------------------------------------------------------------
module tb_zorro_master;

    localparam int TIMEOUT = 64;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        req;
    logic [31:0] req_addr;
    logic        req_read;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        busy;
    logic        ack;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] ADDR;
    logic        READ;
    logic        FCS_n;
    logic [3:0]  DS_n;
    logic        DOE;
    logic [31:0] D_out;
    logic [31:0] D_in  = 32'h0;
    logic        DTACK = 1'b0;
    logic        BERR  = 1'b0;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } expect_t;

    expect_t     sbQueue[$];
    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] modelRdata = 32'h0;

    // Responder behaviour: 0 = silent, 1 = DTACK, 2 = DTACK and BERR together.
    int          respMode  = 1;
    int          respDelay = 2;
    logic [31:0] respData  = 32'h0;
    int          fcsCount  = 0;

    zorro_master #(.TIMEOUT(TIMEOUT)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .req       (req),
        .req_addr  (req_addr),
        .req_read  (req_read),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .busy      (busy),
        .ack       (ack),
        .err       (err),
        .rdata     (rdata),
        .ADDR      (ADDR),
        .READ      (READ),
        .FCS_n     (FCS_n),
        .DS_n      (DS_n),
        .DOE       (DOE),
        .D_out     (D_out),
        .D_in      (D_in),
        .DTACK     (DTACK),
        .BERR      (BERR)
    );

    always #5 CLK = ~CLK;

    // The responder counts cycles with FCS_n low and answers after respDelay
    // of them; it lets go of DTACK/BERR as soon as the master releases FCS_n.
    always @(negedge CLK) begin
        if (RESET === 1'b1 || FCS_n !== 1'b0) begin
            fcsCount = 0;
            DTACK    = 1'b0;
            BERR     = 1'b0;
        end else begin
            fcsCount = fcsCount + 1;
            if (fcsCount >= respDelay && respMode != 0) begin
                D_in  = respData;
                DTACK = 1'b1;
                BERR  = (respMode == 2);
            end
        end
    end

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // Issue one request for a single cycle and queue what its ack should carry.
    task automatic applyStimulus(input logic rd, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] be, input logic expErr, input logic [31:0] expRdata);
        expect_t e;
        @(negedge CLK);
        req_read  = rd;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        req       = 1'b1;
        e.err     = expErr;
        e.rdata   = expRdata;
        sbQueue.push_back(e);
        @(negedge CLK);
        req = 1'b0;
    endtask

    // Wait (bounded) for the ack pulse and compare it against the queue head.
    task automatic checkOutput(input string tag);
        bit      seen;
        expect_t e;
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge CLK);
            if (ack === 1'b1) seen = 1;
        end
        checkBit({tag, "_ack"}, seen, 1'b1);
        if (seen) begin
            checkBit({tag, "_sb_entry"}, sbQueue.size() != 0, 1'b1);
            if (sbQueue.size() != 0) begin
                e = sbQueue.pop_front();
                checkBit({tag, "_err"}, err, e.err);
                checkValue({tag, "_rdata"}, rdata, e.rdata);
            end
        end else if (sbQueue.size() != 0) begin
            e = sbQueue.pop_front();
        end
    endtask

    // WAIT is the only state with FCS_n low and a data strobe active.
    task automatic waitForWait(input string tag, output bit found);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge CLK);
            if (FCS_n === 1'b0 && DS_n !== 4'hF) found = 1;
        end
        checkBit({tag, "_reach_wait"}, found, 1'b1);
    endtask

    // Hard stop in case something above fails to return.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit inWait;
        int waitCycles;
        int ackCount;
        int ackSeen;
        bit sawIdle;
        bit seenLow;
        int highRun;
        int gap;
        expect_t e;

        RESET     = 1'b1;
        req       = 1'b0;
        req_addr  = 32'h0;
        req_read  = 1'b0;
        req_wdata = 32'h0;
        req_be    = 4'h0;

        // Values held while reset is asserted.
        repeat (3) @(negedge CLK);
        checkBit  ("rst_busy",  busy,  1'b0);
        checkBit  ("rst_ack",   ack,   1'b0);
        checkBit  ("rst_err",   err,   1'b0);
        checkValue("rst_rdata", rdata, 32'h0);
        checkValue("rst_addr",  ADDR,  32'h0);
        checkBit  ("rst_read",  READ,  1'b1);
        checkBit  ("rst_fcs",   FCS_n, 1'b1);
        checkValue("rst_ds",    {28'h0, DS_n}, 32'hF);
        checkBit  ("rst_doe",   DOE,   1'b0);
        checkValue("rst_dout",  D_out, 32'h0);
        RESET = 1'b0;
        repeat (2) @(negedge CLK);

        // Read answered two cycles after FCS_n falls.
        respMode = 1;
        respData = 32'hDEADBEEF;
        applyStimulus(1'b1, 32'h0080_0010, 32'h0, 4'hF, 1'b0, 32'hDEADBEEF);
        modelRdata = 32'hDEADBEEF;
        waitForWait("read", inWait);
        checkValue("read_addr", ADDR, 32'h0080_0010);
        checkBit  ("read_dir",  READ, 1'b1);
        checkBit  ("read_doe",  DOE,  1'b0);
        checkValue("read_ds",   {28'h0, DS_n}, 32'h0);
        checkOutput("read");

        // Write of the two low byte lanes.
        applyStimulus(1'b0, 32'h0080_0020, 32'h1234_5678, 4'b0011, 1'b0, modelRdata);
        waitForWait("write", inWait);
        checkValue("write_ds",   {28'h0, DS_n}, 32'hC);
        checkBit  ("write_doe",  DOE,   1'b1);
        checkValue("write_dout", D_out, 32'h1234_5678);
        checkBit  ("write_dir",  READ,  1'b0);
        checkValue("write_addr", ADDR,  32'h0080_0020);
        checkOutput("write");

        // Silent responder: the master gives up after TIMEOUT WAIT cycles.
        respMode = 0;
        applyStimulus(1'b1, 32'h0080_0030, 32'h0, 4'hF, 1'b1, modelRdata);
        waitForWait("timeout", inWait);
        waitCycles = inWait ? 1 : 0;
        for (int i = 0; i < 200 && inWait; i++) begin
            @(negedge CLK);
            if (FCS_n === 1'b0 && DS_n !== 4'hF) waitCycles++;
            else inWait = 0;
        end
        checkValue("timeout_wait_cycles", waitCycles, TIMEOUT);
        checkOutput("timeout");

        // DTACK and BERR together: the error wins and rdata keeps its value.
        respMode = 2;
        respData = 32'hCAFE_F00D;
        applyStimulus(1'b1, 32'h0080_0034, 32'h0, 4'hF, 1'b1, modelRdata);
        checkOutput("berr_dtack");

        // Reset pulse in the middle of WAIT aborts the cycle without an ack.
        respMode = 0;
        @(negedge CLK);
        req_read = 1'b1;
        req_addr = 32'h0080_0040;
        req_be   = 4'hF;
        req      = 1'b1;
        @(negedge CLK);
        req = 1'b0;
        waitForWait("abort", inWait);
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        checkBit  ("abort_fcs",   FCS_n, 1'b1);
        checkValue("abort_ds",    {28'h0, DS_n}, 32'hF);
        checkBit  ("abort_busy",  busy,  1'b0);
        checkValue("abort_rdata", rdata, 32'h0);
        modelRdata = 32'h0;
        @(negedge CLK);
        RESET    = 1'b0;
        ackCount = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (ack === 1'b1) ackCount++;
        end
        checkValue("abort_no_ack", ackCount, 0);

        // Ordinary read straight after the abort.
        respMode = 1;
        respData = 32'h0BAD_CAFE;
        applyStimulus(1'b1, 32'h0080_0050, 32'h0, 4'hF, 1'b0, 32'h0BAD_CAFE);
        modelRdata = 32'h0BAD_CAFE;
        checkOutput("post_reset_read");

        // req held high: two full write cycles with FCS_n released in between.
        @(negedge CLK);
        req_read  = 1'b0;
        req_addr  = 32'h0080_0060;
        req_wdata = 32'hA5A5_5A5A;
        req_be    = 4'hF;
        req       = 1'b1;
        e.err     = 1'b0;
        e.rdata   = modelRdata;
        sbQueue.push_back(e);
        sbQueue.push_back(e);
        ackSeen = 0;
        sawIdle = 0;
        seenLow = 0;
        highRun = 0;
        gap     = -1;
        for (int i = 0; i < 400 && ackSeen < 2; i++) begin
            @(negedge CLK);
            if (FCS_n === 1'b0) begin
                if (seenLow && highRun > 0 && gap < 0) gap = highRun;
                seenLow = 1;
                highRun = 0;
            end else if (seenLow) begin
                highRun++;
            end
            if (ack === 1'b1) begin
                ackSeen++;
                checkBit("b2b_sb_entry", sbQueue.size() != 0, 1'b1);
                if (sbQueue.size() != 0) begin
                    e = sbQueue.pop_front();
                    checkBit  ("b2b_err",   err,   e.err);
                    checkValue("b2b_rdata", rdata, e.rdata);
                end
            end
            if (ackSeen == 1 && busy === 1'b0) sawIdle = 1;
            if (sawIdle && busy === 1'b1) req = 1'b0;
        end
        req = 1'b0;
        checkValue("b2b_ack_count", ackSeen, 2);
        checkBit  ("b2b_fcs_gap_min4", gap >= 4, 1'b1);

        repeat (5) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
